// File: rtl/game_flow_pkg.sv
// Shared definitions for the dino game flow controller: state encodings
// driven onto gameState and a constant-width helper.
package game_flow_pkg;

    localparam int GAME_STATE_W = 4;

    localparam logic [GAME_STATE_W-1:0] GAME_MENU    = 4'd0;
    localparam logic [GAME_STATE_W-1:0] GAME_RUNNING = 4'd1;
    localparam logic [GAME_STATE_W-1:0] GAME_PAUSE   = 4'd2;
    localparam logic [GAME_STATE_W-1:0] GAME_OVER    = 4'd3;
    localparam logic [GAME_STATE_W-1:0] GAME_RESPAWN = 4'd4;

    // Ceiling log2, usable in constant expressions; clog2(1) == 0.
    function automatic int clog2(input int value);
        int result;
        int rem;
        result = 0;
        rem    = value - 1;
        while (rem > 0) begin
            result = result + 1;
            rem    = rem >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/game_flow_ctrl_debounce.sv
// Single-input debouncer: the level follows the raw input only after it has
// disagreed for DEBOUNCE_CYCLES consecutive clocks; rise marks a 0->1 flip.
module btn_debounce
    import game_flow_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic resetn,
    input  logic raw,
    output logic level,
    output logic rise
);

    localparam int                CNT_W    = clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [CNT_W-1:0] cnt;

    // NOTE: state is updated only with non-blocking assignments so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            cnt   <= '0;
            level <= 1'b0;
            rise  <= 1'b0;
        end else begin
            rise <= 1'b0;
            if (raw == level) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                cnt   <= '0;
                level <= raw;
                rise  <= raw;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/game_flow_ctrl.sv
// Top-level game flow FSM: MENU / RUNNING / PAUSE / RESPAWN / OVER with
// debounced buttons, a life budget and frame-based hold/grace timers.
module game_flow_ctrl
    import game_flow_pkg::*;
#(
    parameter int NUM_BTN              = 2,
    parameter int DEBOUNCE_CYCLES      = 4,
    parameter int LIVES                = 3,
    parameter int RESPAWN_FRAMES       = 30,
    parameter int OVER_HOLD_FRAMES     = 60,
    parameter int PAUSE_TIMEOUT_FRAMES = 0
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic                    frameClk,
    input  logic [NUM_BTN-1:0]      btn,
    input  logic                    pause,
    input  logic                    collision,
    output logic [GAME_STATE_W-1:0] gameState,
    output logic [3:0]              lives,
    output logic                    new_game,
    output logic                    frame_run,
    output logic                    running
);

    localparam int FRAME_PEAK_RO = (RESPAWN_FRAMES > OVER_HOLD_FRAMES) ?
                                   RESPAWN_FRAMES : OVER_HOLD_FRAMES;
    localparam int FRAME_PEAK    = (PAUSE_TIMEOUT_FRAMES > FRAME_PEAK_RO) ?
                                   PAUSE_TIMEOUT_FRAMES : FRAME_PEAK_RO;
    localparam int FRAME_W       = clog2(FRAME_PEAK) + 1;

    localparam logic [FRAME_W-1:0] FRAME_SAT   = {FRAME_W{1'b1}};
    localparam logic [FRAME_W-1:0] RESPAWN_CNT = FRAME_W'(RESPAWN_FRAMES);
    localparam logic [FRAME_W-1:0] OVER_CNT    = FRAME_W'(OVER_HOLD_FRAMES);
    localparam logic [FRAME_W-1:0] PAUSE_CNT   = FRAME_W'(PAUSE_TIMEOUT_FRAMES);
    localparam logic [3:0]         LIVES_INIT  = 4'(LIVES);

    logic [NUM_BTN-1:0] btn_level;
    logic [NUM_BTN-1:0] btn_rise;
    logic               pause_level_unused;
    logic               pause_rise;

    for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
        btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
            .clk    (clk),
            .resetn (resetn),
            .raw    (btn[i]),
            .level  (btn_level[i]),
            .rise   (btn_rise[i])
        );
    end

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_pause_db (
        .clk    (clk),
        .resetn (resetn),
        .raw    (pause),
        .level  (pause_level_unused),
        .rise   (pause_rise)
    );

    logic btn_any_q;
    logic start_evt;
    logic pause_evt;

    // A button rising while the OR was already high is not a new start edge.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            btn_any_q <= 1'b0;
            start_evt <= 1'b0;
            pause_evt <= 1'b0;
        end else begin
            btn_any_q <= |btn_level;
            start_evt <= ((|btn_rise) & ~btn_any_q) | pause_rise;
            pause_evt <= pause_rise;
        end
    end

    logic [GAME_STATE_W-1:0] state;
    logic [GAME_STATE_W-1:0] state_nxt;
    logic [3:0]              lives_nxt;
    logic                    new_game_nxt;
    logic [FRAME_W-1:0]      frame_cnt;
    logic [FRAME_W-1:0]      frame_cnt_inc;

    always_comb begin
        frame_cnt_inc = frame_cnt;
        if (frameClk && (frame_cnt != FRAME_SAT)) begin
            frame_cnt_inc = frame_cnt + 1'b1;
        end
    end

    // NOTE: every output of this block gets a default first, so no path can
    // leave a value unassigned and infer a latch.
    always_comb begin
        state_nxt    = state;
        lives_nxt    = lives;
        new_game_nxt = 1'b0;
        case (state)
            GAME_MENU: begin
                if (start_evt) begin
                    state_nxt    = GAME_RUNNING;
                    lives_nxt    = LIVES_INIT;
                    new_game_nxt = 1'b1;
                end
            end
            GAME_RUNNING: begin
                if (collision) begin
                    if (lives > 4'd1) begin
                        lives_nxt = lives - 4'd1;
                        state_nxt = GAME_RESPAWN;
                    end else begin
                        lives_nxt = 4'd0;
                        state_nxt = GAME_OVER;
                    end
                end else if (pause_evt) begin
                    state_nxt = GAME_PAUSE;
                end
            end
            GAME_PAUSE: begin
                if (pause_evt) begin
                    state_nxt = GAME_RUNNING;
                end else if ((PAUSE_TIMEOUT_FRAMES != 0) && (frame_cnt_inc >= PAUSE_CNT)) begin
                    state_nxt = GAME_MENU;
                end
            end
            GAME_RESPAWN: begin
                if (frame_cnt_inc >= RESPAWN_CNT) begin
                    state_nxt = GAME_RUNNING;
                end
            end
            GAME_OVER: begin
                if (start_evt && (frame_cnt >= OVER_CNT)) begin
                    state_nxt = GAME_MENU;
                end
            end
            default: state_nxt = GAME_MENU;
        endcase
    end

    // The frame counter restarts on every state change so each timer measures
    // frames spent in the current state only.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state     <= GAME_MENU;
            lives     <= LIVES_INIT;
            new_game  <= 1'b0;
            frame_cnt <= '0;
        end else begin
            state     <= state_nxt;
            lives     <= lives_nxt;
            new_game  <= new_game_nxt;
            frame_cnt <= (state_nxt != state) ? '0 : frame_cnt_inc;
        end
    end

    assign gameState = state;
    assign running   = (state == GAME_RUNNING);
    assign frame_run = frameClk & running;

endmodule

// File: tb/tb_game_flow_ctrl.sv
// Self-checking bench for game_flow_ctrl: a vector table driven through a
// scoreboard queue plus hand-written multi-cycle sequences.
module tb_game_flow_ctrl;
    import game_flow_pkg::*;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic       frameClk = 1'b0;
    logic [1:0] btn = 2'b00;
    logic       pause = 1'b0;
    logic       collision = 1'b0;
    logic [3:0] gameState;
    logic [3:0] lives;
    logic       new_game;
    logic       frame_run;
    logic       running;

    logic       frame2 = 1'b0;
    logic [1:0] btn2 = 2'b00;
    logic       pause2 = 1'b0;
    logic [3:0] state2;
    logic [3:0] lives2;
    logic       new_game2;
    logic       frame_run2;
    logic       running2;

    always #5 clk = ~clk;

    game_flow_ctrl #(
        .NUM_BTN(2), .DEBOUNCE_CYCLES(4), .LIVES(3), .RESPAWN_FRAMES(2),
        .OVER_HOLD_FRAMES(60), .PAUSE_TIMEOUT_FRAMES(5)
    ) dut (
        .clk(clk), .resetn(resetn), .frameClk(frameClk), .btn(btn),
        .pause(pause), .collision(collision), .gameState(gameState),
        .lives(lives), .new_game(new_game), .frame_run(frame_run),
        .running(running)
    );

    game_flow_ctrl #(
        .NUM_BTN(2), .DEBOUNCE_CYCLES(4), .LIVES(3), .RESPAWN_FRAMES(2),
        .OVER_HOLD_FRAMES(60), .PAUSE_TIMEOUT_FRAMES(0)
    ) dut_nt (
        .clk(clk), .resetn(resetn), .frameClk(frame2), .btn(btn2),
        .pause(pause2), .collision(1'b0), .gameState(state2),
        .lives(lives2), .new_game(new_game2), .frame_run(frame_run2),
        .running(running2)
    );

    int n_tests   = 0;
    int n_fail    = 0;
    int ng_count  = 0;
    int ng2_count = 0;
    int first_run = 0;
    int pulses    = 0;

    // new_game pulses are tallied just after each edge
    always @(posedge clk) begin
        #1;
        if (new_game === 1'b1) ng_count++;
        if (new_game2 === 1'b1) ng2_count++;
    end

    typedef struct {
        string      name;
        logic [1:0] btn;
        logic       pause;
        logic       coll;
        int         frames;
        int         cycles;
        logic [3:0] st;
        logic [3:0] lv;
        int         ng;
        logic       fr;
    } vec_t;

    typedef struct {
        string      name;
        logic [3:0] st;
        logic [3:0] lv;
        int         ng;
    } exp_t;

    vec_t vecs[30];
    exp_t sb[$];

    function automatic vec_t mk(input string n, input logic [1:0] b, input logic p,
                                input logic c, input int f, input int cy,
                                input logic [3:0] st, input logic [3:0] lv,
                                input int ng, input logic fr);
        vec_t v;
        v.name = n; v.btn = b; v.pause = p; v.coll = c; v.frames = f;
        v.cycles = cy; v.st = st; v.lv = lv; v.ng = ng; v.fr = fr;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    // Frame pulses occupy even cycles; frame_run is sampled on the first pulse.
    task automatic run_vec(input vec_t v);
        exp_t e;
        btn       = v.btn;
        pause     = v.pause;
        collision = v.coll;
        e.name = v.name; e.st = v.st; e.lv = v.lv; e.ng = v.ng;
        sb.push_back(e);
        for (int c = 0; c < v.cycles; c++) begin
            frameClk = (c < 2 * v.frames) && (c % 2 == 0);
            @(negedge clk);
            if (c == 0 && v.frames > 0) check({v.name, "_frame_run"}, 32'(frame_run), 32'(v.fr));
        end
        frameClk = 1'b0;
        e = sb.pop_front();
        check({e.name, "_state"}, 32'(gameState), 32'(e.st));
        check({e.name, "_lives"}, 32'(lives), 32'(e.lv));
        check({e.name, "_new_games"}, 32'(ng_count), 32'(e.ng));
    endtask

    initial begin
        //                name            btn    p     c     fr  cyc  state         lives ng fr
        vecs[0]  = mk("glitch",        2'b01, 1'b0, 1'b0,  0,   3, GAME_MENU,    4'd3, 0, 1'b0);
        vecs[1]  = mk("glitch_rel",    2'b00, 1'b0, 1'b0,  0,   8, GAME_MENU,    4'd3, 0, 1'b0);
        vecs[2]  = mk("coll1",         2'b00, 1'b0, 1'b1,  0,   1, GAME_RESPAWN, 4'd2, 1, 1'b0);
        vecs[3]  = mk("coll_ignored",  2'b00, 1'b0, 1'b1,  0,   3, GAME_RESPAWN, 4'd2, 1, 1'b0);
        vecs[4]  = mk("resp_frame1",   2'b00, 1'b0, 1'b0,  1,   2, GAME_RESPAWN, 4'd2, 1, 1'b0);
        vecs[5]  = mk("resp_frame2",   2'b00, 1'b0, 1'b0,  1,   2, GAME_RUNNING, 4'd2, 1, 1'b1);
        vecs[6]  = mk("pause_on",      2'b00, 1'b1, 1'b0,  0,   8, GAME_PAUSE,   4'd2, 1, 1'b0);
        vecs[7]  = mk("pause_rel",     2'b00, 1'b0, 1'b0,  0,   8, GAME_PAUSE,   4'd2, 1, 1'b0);
        vecs[8]  = mk("resume",        2'b00, 1'b1, 1'b0,  0,   8, GAME_RUNNING, 4'd2, 1, 1'b0);
        vecs[9]  = mk("resume_rel",    2'b00, 1'b0, 1'b0,  0,   8, GAME_RUNNING, 4'd2, 1, 1'b0);
        vecs[10] = mk("prio_resp",     2'b00, 1'b0, 1'b0,  2,   8, GAME_RUNNING, 4'd1, 1, 1'b0);
        vecs[11] = mk("fatal_pause",   2'b00, 1'b1, 1'b1,  0,   8, GAME_OVER,    4'd0, 1, 1'b0);
        vecs[12] = mk("fatal_rel",     2'b00, 1'b0, 1'b0,  0,   8, GAME_OVER,    4'd0, 1, 1'b0);
        vecs[13] = mk("over_f10",      2'b00, 1'b0, 1'b0, 10,  20, GAME_OVER,    4'd0, 1, 1'b0);
        vecs[14] = mk("early_start",   2'b01, 1'b0, 1'b0,  0,  10, GAME_OVER,    4'd0, 1, 1'b0);
        vecs[15] = mk("early_rel",     2'b00, 1'b0, 1'b0,  0,   8, GAME_OVER,    4'd0, 1, 1'b0);
        vecs[16] = mk("over_f65",      2'b00, 1'b0, 1'b0, 55, 110, GAME_OVER,    4'd0, 1, 1'b0);
        vecs[17] = mk("late_start",    2'b10, 1'b0, 1'b0,  0,  10, GAME_MENU,    4'd0, 1, 1'b0);
        vecs[18] = mk("late_rel",      2'b00, 1'b0, 1'b0,  0,   8, GAME_MENU,    4'd0, 1, 1'b0);
        vecs[19] = mk("restart",       2'b01, 1'b0, 1'b0,  0,  10, GAME_RUNNING, 4'd3, 2, 1'b0);
        vecs[20] = mk("restart_rel",   2'b00, 1'b0, 1'b0,  0,   8, GAME_RUNNING, 4'd3, 2, 1'b0);
        vecs[21] = mk("to_pause",      2'b00, 1'b1, 1'b0,  0,   8, GAME_PAUSE,   4'd3, 2, 1'b0);
        vecs[22] = mk("pause_f4",      2'b00, 1'b0, 1'b0,  4,   8, GAME_PAUSE,   4'd3, 2, 1'b0);
        vecs[23] = mk("pause_timeout", 2'b00, 1'b0, 1'b0,  1,   2, GAME_MENU,    4'd3, 2, 1'b0);
        vecs[24] = mk("start_both",    2'b11, 1'b0, 1'b0,  0,  10, GAME_RUNNING, 4'd3, 3, 1'b0);
        vecs[25] = mk("start_rel",     2'b00, 1'b0, 1'b0,  0,   8, GAME_RUNNING, 4'd3, 3, 1'b0);
        vecs[26] = mk("coll_a",        2'b00, 1'b0, 1'b1,  0,   1, GAME_RESPAWN, 4'd2, 3, 1'b0);
        vecs[27] = mk("resp_a",        2'b00, 1'b0, 1'b0,  2,   4, GAME_RUNNING, 4'd2, 3, 1'b0);
        vecs[28] = mk("coll_b",        2'b00, 1'b0, 1'b1,  0,   1, GAME_RESPAWN, 4'd1, 3, 1'b0);
        vecs[29] = mk("resp_b",        2'b00, 1'b0, 1'b0,  2,   4, GAME_RUNNING, 4'd1, 3, 1'b0);

        // Reset values, with frameClk high to show frame_run stays low outside RUNNING
        resetn   = 1'b0;
        frameClk = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_state", 32'(gameState), 32'(GAME_MENU));
        check("reset_lives", 32'(lives), 32'd3);
        check("reset_new_game", 32'(new_game), 32'd0);
        check("reset_running", 32'(running), 32'd0);
        check("reset_frame_run", 32'(frame_run), 32'd0);
        frameClk = 1'b0;
        resetn   = 1'b1;
        @(negedge clk);

        for (int i = 0; i <= 1; i++) run_vec(vecs[i]);

        // Held start button: RUNNING within 7 cycles, exactly one new_game pulse
        btn = 2'b01;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (new_game === 1'b1) pulses++;
            if (first_run == 0 && gameState == GAME_RUNNING) first_run = k;
        end
        check("start_latency_ok", 32'((first_run >= 1) && (first_run <= 7)), 32'd1);
        check("start_state", 32'(gameState), 32'(GAME_RUNNING));
        check("start_new_game_pulses", 32'(pulses), 32'd1);
        check("start_lives", 32'(lives), 32'd3);
        check("start_running", 32'(running), 32'd1);
        btn = 2'b00;
        repeat (8) @(negedge clk);

        for (int i = 2; i <= 9; i++) run_vec(vecs[i]);

        // Collision in the same cycle as pause_evt: collision wins
        pause = 1'b1;
        repeat (5) @(negedge clk);
        collision = 1'b1;
        @(negedge clk);
        collision = 1'b0;
        check("prio_state", 32'(gameState), 32'(GAME_RESPAWN));
        check("prio_lives", 32'(lives), 32'd1);

        for (int i = 10; i <= 29; i++) run_vec(vecs[i]);

        // One-cycle reset mid-game with a single life left
        resetn = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        check("midreset_state", 32'(gameState), 32'(GAME_MENU));
        check("midreset_lives", 32'(lives), 32'd3);
        check("midreset_new_game", 32'(new_game), 32'd0);
        @(negedge clk);
        check("midreset_after_state", 32'(gameState), 32'(GAME_MENU));
        check("midreset_new_game_count", 32'(ng_count), 32'd3);

        // Timeout disabled: a long pause survives, second press resumes
        btn2 = 2'b01;
        repeat (10) @(negedge clk);
        btn2 = 2'b00;
        repeat (8) @(negedge clk);
        check("nt_start_state", 32'(state2), 32'(GAME_RUNNING));
        pause2 = 1'b1;
        repeat (8) @(negedge clk);
        pause2 = 1'b0;
        repeat (8) @(negedge clk);
        check("nt_pause_state", 32'(state2), 32'(GAME_PAUSE));
        for (int f = 0; f < 1000; f++) begin
            frame2 = 1'b1;
            @(negedge clk);
            frame2 = 1'b0;
            @(negedge clk);
        end
        check("nt_after_1000_frames", 32'(state2), 32'(GAME_PAUSE));
        pause2 = 1'b1;
        repeat (8) @(negedge clk);
        pause2 = 1'b0;
        check("nt_resume_state", 32'(state2), 32'(GAME_RUNNING));
        check("nt_resume_running", 32'(running2), 32'd1);
        check("nt_resume_lives", 32'(lives2), 32'd3);
        check("nt_new_game_count", 32'(ng2_count), 32'd1);
        check("nt_frame_run_idle", 32'(frame_run2), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
